sm_fixmul_seq: RTL
==================

# sm_fixmul_seq

Sequential sign-magnitude fixed-point multiplier: the inverse-direction companion to the moving-average integer divider. It takes an 8-bit signed integer sample and a 12-bit signed Q7.4 coefficient, both in sign-magnitude format (the divider's quotient format). It returns their exact product using one shift-add step per cycle. It scales averages and reconstructs sums, and sits on the datapath between the divider output and downstream accumulation, with a valid/ready handshake on both sides.

## Interface
- A_W, 8, width of operand a: bit A_W-1 sign, rest integer magnitude
- B_W, 12, width of operand b: bit B_W-1 sign, [B_W-2:FRAC] integer magnitude, [FRAC-1:0] fraction
- FRAC, 4, fractional bits in b and in the product
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands (IDLE only)
- a  in  A_W  sign-magnitude integer operand
- b  in  B_W  sign-magnitude fixed-point operand
- out_valid  out  1  product valid, held until taken
- out_ready  in  1  consumer takes product
- product  out  P_W = A_W+B_W-1 (19)  sign-magnitude: bit P_W-1 sign, [P_W-2:FRAC] integer magnitude, [FRAC-1:0] fraction
- busy  out  1  high in BUSY

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid=1, capture |a| = a[A_W-2:0] and |b| = b[B_W-2:0], sign = a[A_W-1]^b[B_W-1], clear accumulator, count=0, then go to BUSY.
- BUSY: B_W-1 iterations, one per cycle, multiplier bits LSB first. If the current bit of |b| is 1, add |a| << count into the accumulator. Increment count. After the iteration with count=B_W-2, go to DONE.
- The accumulator is P_W-1 bits wide. No overflow is possible: max 127*2047 = 0x3F781 < 2^18. No rounding or truncation; the FRAC fraction bits pass straight through.
- DONE: out_valid=1, product={sign_out, acc}.
- Negative zero: if acc==0, sign_out=0 regardless of operand signs. A magnitude-0 operand with sign 1 is treated as zero.
- DONE with out_ready=1: go to IDLE. There is no same-cycle new accept; in_ready rises the cycle after the handshake.
- Operands are registered at accept. Changes on a/b after accept do not affect the result.
- in_valid while BUSY/DONE is ignored (in_ready=0). The upstream must hold operands until in_ready.

## Timing
- Reset (rst_n=0 at a clock edge): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator/count=0.
- Reset mid-operation (BUSY or DONE) aborts. The result is discarded and no out_valid pulse is produced.
- Accept at edge T0. BUSY for cycles T0+1 … T0+11, with busy=1. out_valid=1 from T0+12.
- Fixed latency B_W (12) cycles from accept to out_valid. Independent of operand values, including zero.
- Throughput with out_ready tied high: one product per 14 cycles (accept, 11 BUSY, DONE, IDLE).
- product and out_valid stay stable while out_ready=0 (backpressure has no time limit).
- product holds its last value after the handshake until the next DONE. Consumers qualify it with out_valid.

## Test plan
- a=0x05, b=0x028 (2.5) -> out_valid exactly 12 cycles after accept, product=0x000C8 (12.5).
- a=0x85 (-5), b=0x028 -> product=0x400C8. a=0x85, b=0x828 -> product=0x000C8 (signs cancel).
- a=0x7F, b=0x7FF (127.9375) -> product=0x3F781. No overflow; the sign bit is unaffected.
- a=0x80 (-0), b=0x828 -> product=0x00000 (negative zero suppressed), latency still 12.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and product stable, in_ready=0; on the handshake, in_ready=1 the next cycle. Back-to-back jobs with in_valid held high -> 14-cycle spacing.
- Assert rst_n=0 for one edge at cycle 5 of BUSY -> next cycle in_ready=1, out_valid=0, product=0. The next job (0x05 × 0x028) gives 0x000C8 with normal latency.

Source files
------------

// File: rtl/sm_fixmul_seq.sv
// rtl/sm_fixmul_seq.sv - sequential sign-magnitude fixed-point shift-add multiplier
//
// Purpose: multiplies a sign-magnitude integer (a) by a sign-magnitude Q fixed-point
// coefficient (b). Each cycle performs one shift-add step on the magnitudes. The
// product is exact: the FRAC fraction bits of b pass straight through to the result.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready is high only while idle
//   a [A_W-1:0]          sign-magnitude integer operand
//   b [B_W-1:0]          sign-magnitude fixed-point operand (FRAC fraction bits)
//   out_valid / out_ready result handshake; product is held until taken
//   product [P_W-1:0]    sign-magnitude result (FRAC fraction bits)
//   busy                 high while shift-add iterations are running
module sm_fixmul_seq #(
   parameter int A_W  = 8,
   parameter int B_W  = 12,
   parameter int FRAC = 4,
   localparam int P_W = A_W + B_W - 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [P_W-1:0] product,
   output logic           busy
);

   localparam int CNT_W = $clog2(B_W - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   // Set for the single cycle after accept. The operands are already registered
   // and the datapath is cleared. The iterations start on the next cycle, so the
   // latency is a fixed B_W cycles.
   logic             loaded;
   logic [CNT_W-1:0] count;
   logic             sign;
   logic [P_W-2:0]   mcand;     // |a|, shifted left once per iteration
   logic [B_W-2:0]   mplier;    // |b|, shifted right; bit 0 is the current multiplier bit
   logic [P_W-2:0]   acc;
   logic [P_W-2:0]   acc_sum;

   logic             res_sign;
   logic [P_W-2:FRAC] res_int;
   logic [FRAC-1:0]  res_frac;

   assign acc_sum = acc + (mplier[0] ? mcand : '0);

   assign in_ready  = (state == S_IDLE) && !loaded;
   assign busy      = (state == S_BUSY);
   assign out_valid = (state == S_DONE);
   assign product   = {res_sign, res_int, res_frac};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         loaded   <= 1'b0;
         count    <= '0;
         sign     <= 1'b0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         res_sign <= 1'b0;
         res_int  <= '0;
         res_frac <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (loaded) begin
                  loaded <= 1'b0;
                  state  <= S_BUSY;
               end else if (in_valid) begin
                  mcand  <= {{(P_W - A_W){1'b0}}, a[A_W-2:0]};
                  mplier <= b[B_W-2:0];
                  sign   <= a[A_W-1] ^ b[B_W-1];
                  acc    <= '0;
                  count  <= '0;
                  loaded <= 1'b1;
               end
            end
            S_BUSY: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + CNT_W'(1);
               if (count == CNT_W'(B_W - 2)) begin
                  state <= S_DONE;
                  // A zero magnitude always reports a positive sign, so a product
                  // of -0 never reaches the output.
                  res_sign            <= sign & (|acc_sum);
                  {res_int, res_frac} <= acc_sum;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
